prog_hex_dump: RTL and testbench

- Writer side of the program-image path: streams a 256x16 program memory out as the same ASCII text that the program loader consumes.
- Each word is emitted as 4 hex digits followed by '\n' (0x0A), one word per line, starting at address 0.
- Sits between the program RAM's read port and a byte-wide transmit sink (UART TX FIFO or testbench capture).
- Used to read back a loaded image for checking, and to save an image.

---
 rtl/prog_hex_dump.sv | 138 +++++++++++++
 tb/tb_prog_hex_dump.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_hex_dump.sv
// Streams words of a program RAM out as ASCII hex text, one word per line,
// through a valid/ready byte interface.
module prog_hex_dump #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int UPPER  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);
   localparam int              DIGITS = DATA_W / 4;
   localparam int              DCNT_W = $clog2(DIGITS + 1);
   localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_SEND, S_EOL, S_FIN} state_t;

   state_t              r_state;
   logic [ADDR_W:0]     r_cnt;
   logic [ADDR_W:0]     r_idx;
   logic [DATA_W-1:0]   r_shift;
   logic [DCNT_W-1:0]   r_dig;
   logic                r_busy;
   logic                r_done;
   logic                r_rd_en;
   logic [ADDR_W-1:0]   r_addr;
   logic [7:0]          r_tx_data;
   logic                r_tx_valid;

   logic                w_xfer;
   logic [DATA_W-1:0]   w_shift_nxt;
   logic [ADDR_W:0]     w_idx_nxt;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else if (UPPER != 0)
         return 8'h37 + {4'h0, n};
      else
         return 8'h57 + {4'h0, n};
   endfunction

   assign w_xfer      = r_tx_valid & tx_ready;
   assign w_shift_nxt = {r_shift[DATA_W-5:0], 4'h0};
   assign w_idx_nxt   = r_idx + {{ADDR_W{1'b0}}, 1'b1};

   // Dump sequencer: every output is a register updated on the state transition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_dig      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rd_en    <= 1'b0;
         r_addr     <= '0;
         r_tx_data  <= 8'h00;
         r_tx_valid <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_rd_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx <= '0;
                  if (count == '0) begin
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_cnt   <= (count > DEPTH) ? DEPTH : count;
                     r_busy  <= 1'b1;
                     r_rd_en <= 1'b1;
                     r_addr  <= '0;
                     r_state <= S_READ;
                  end
               end
            end
            S_READ: r_state <= S_CAPT;
            // RAM data is valid in this cycle, one cycle after the read strobe
            S_CAPT: begin
               r_shift    <= mem_rdata;
               r_dig      <= DCNT_W'(DIGITS);
               r_tx_data  <= hex_ascii(mem_rdata[DATA_W-1 -: 4]);
               r_tx_valid <= 1'b1;
               r_state    <= S_SEND;
            end
            S_SEND: begin
               if (w_xfer) begin
                  r_shift <= w_shift_nxt;
                  r_dig   <= r_dig - DCNT_W'(1);
                  if (r_dig == DCNT_W'(1)) begin
                     r_tx_data <= 8'h0A;
                     r_state   <= S_EOL;
                  end else begin
                     r_tx_data <= hex_ascii(w_shift_nxt[DATA_W-1 -: 4]);
                  end
               end
            end
            S_EOL: begin
               if (w_xfer) begin
                  r_idx      <= w_idx_nxt;
                  r_tx_valid <= 1'b0;
                  if (w_idx_nxt == r_cnt) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_rd_en <= 1'b1;
                     r_addr  <= w_idx_nxt[ADDR_W-1:0];
                     r_state <= S_READ;
                  end
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign mem_rd_en = r_rd_en;
   assign mem_addr  = r_addr;
   assign tx_data   = r_tx_data;
   assign tx_valid  = r_tx_valid;

endmodule

// File: tb/tb_prog_hex_dump.sv
// Directed bench for prog_hex_dump: lower-case and upper-case instances,
// byte/address scoreboards fed at stimulus time and drained by negedge monitors.
module tb_prog_hex_dump;
   logic        clk = 1'b0;
   logic        rst_n, start, start_u, tx_ready;
   logic [8:0]  count;
   logic        busy, done, rd_en, busy_u, done_u, rd_en_u;
   logic [7:0]  addr, addr_u, tx_data, tx_data_u;
   logic        tx_valid, tx_valid_u;
   logic [15:0] rdata, rdata_u;
   logic [15:0] mem [256];

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int n_done = 0, n_done_u = 0, n_bytes = 0;
   bit mon_en = 1'b1, zero_dump = 1'b0, bp_mode = 1'b0;
   logic [7:0] bq[$], bq_u[$], aq[$];

   prog_hex_dump #(.ADDR_W(8), .DATA_W(16), .UPPER(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .count(count), .busy(busy), .done(done),
      .mem_rd_en(rd_en), .mem_addr(addr), .mem_rdata(rdata),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready));

   prog_hex_dump #(.ADDR_W(8), .DATA_W(16), .UPPER(1)) u_up (
      .clk(clk), .rst_n(rst_n), .start(start_u), .count(count), .busy(busy_u), .done(done_u),
      .mem_rd_en(rd_en_u), .mem_addr(addr_u), .mem_rdata(rdata_u),
      .tx_data(tx_data_u), .tx_valid(tx_valid_u), .tx_ready(tx_ready));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en)   rdata   <= mem[addr];
      if (rd_en_u) rdata_u <= mem[addr_u];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return (up ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_exp(input bit up, input int cnt);
      int n;
      logic [15:0] w;
      n = (cnt > 256) ? 256 : cnt;
      for (int i = 0; i < n; i++) begin
         w = mem[i];
         if (!up) aq.push_back(8'(i));
         for (int d = 3; d >= 0; d--)
            if (up) bq_u.push_back(hexc(w[4*d +: 4], up)); else bq.push_back(hexc(w[4*d +: 4], up));
         if (up) bq_u.push_back(8'h0A); else bq.push_back(8'h0A);
      end
   endtask

   task automatic start_dump(input bit up, input logic [8:0] cnt);
      count = cnt;
      if (up) start_u = 1'b1; else start = 1'b1;
      tick();
      start = 1'b0; start_u = 1'b0;
   endtask

   task automatic wait_done(input bit up, input int target, input int budget);
      int k = 0;
      while ((up ? n_done_u : n_done) < target && k < budget) begin tick(); k++; end
      check("done_timeout", ((up ? n_done_u : n_done) >= target), 1);
      tick();
      check("queue_drained", up ? bq_u.size() : bq.size() + aq.size(), 0);
   endtask

   task automatic check_idle_outputs();
      check("rst_busy", busy, 0);   check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0); check("rst_addr", addr, 0);
      check("rst_tx_data", tx_data, 0); check("rst_tx_valid", tx_valid, 0);
   endtask

   // Main-instance monitor: address order, byte values, hold under stall, done placement
   logic [7:0] prev_data;
   bit prev_stall = 1'b0, prev_eol = 1'b0;
   always @(negedge clk) begin
      if (!mon_en) begin
         bq.delete(); aq.delete();
         prev_stall = 1'b0; prev_eol = 1'b0;
      end else begin
         if (rd_en) begin
            check("addr_expected", aq.size() != 0, 1);
            if (aq.size() != 0) check("mem_addr", addr, aq.pop_front());
         end
         if (prev_stall) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, prev_data);
         end
         if (tx_valid && tx_ready) begin
            n_bytes++;
            check("byte_expected", bq.size() != 0, 1);
            if (bq.size() != 0) check("tx_data", tx_data, bq.pop_front());
         end
         if (done) begin
            n_done++;
            check("done_busy_low", busy, 0);
            if (!zero_dump) check("done_after_eol", prev_eol, 1);
         end
         prev_stall = tx_valid && !tx_ready;
         prev_eol   = tx_valid && tx_ready && (tx_data == 8'h0A);
         prev_data  = tx_data;
      end
   end

   // Upper-case instance monitor: byte values and hold under stall
   logic [7:0] prev_data_u;
   bit prev_stall_u = 1'b0;
   always @(negedge clk) begin
      if (prev_stall_u) begin
         check("u_hold_valid", tx_valid_u, 1);
         check("u_hold_data", tx_data_u, prev_data_u);
      end
      if (tx_valid_u && tx_ready) begin
         check("u_byte_expected", bq_u.size() != 0, 1);
         if (bq_u.size() != 0) check("u_tx_data", tx_data_u, bq_u.pop_front());
      end
      if (done_u) n_done_u++;
      prev_stall_u = tx_valid_u && !tx_ready;
      prev_data_u  = tx_data_u;
   end

   // Sink ready: always high, or a repeating 1-0-0-1 pattern when backpressure is on
   initial begin
      int ph = 0;
      tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bp_mode) begin
            tx_ready = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
         end else begin
            tx_ready = 1'b1;
         end
      end
   end

   initial begin
      int b0, d0;
      rst_n = 1'b0; start = 1'b0; start_u = 1'b0; count = 9'd0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      tick(); tick();
      check_idle_outputs();
      rst_n = 1'b1;
      tick();

      // Single word with latency checks
      mem[0] = 16'h1A2F;
      push_exp(1'b0, 1);
      start_dump(1'b0, 9'd1);
      check("busy_rise", busy, 1);
      check("valid_read", tx_valid, 0);
      tick();
      check("valid_capt", tx_valid, 0);
      tick();
      check("first_valid", tx_valid, 1);
      wait_done(1'b0, 1, 50);

      // Backpressure on upper-case instance
      mem[0] = 16'hBEEF;
      bp_mode = 1'b1;
      push_exp(1'b1, 1);
      start_dump(1'b1, 9'd1);
      wait_done(1'b1, 1, 200);
      bp_mode = 1'b0;
      tick();

      // Full memory dump
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
      b0 = n_bytes; d0 = n_done;
      push_exp(1'b0, 256);
      start_dump(1'b0, 9'd256);
      wait_done(1'b0, d0 + 1, 3000);
      repeat (3) tick();
      check("full_bytes", n_bytes - b0, 1280);
      check("full_one_done", n_done - d0, 1);

      // Zero-length dump
      b0 = n_bytes; d0 = n_done;
      zero_dump = 1'b1;
      start_dump(1'b0, 9'd0);
      check("zero_busy", busy, 0);
      check("zero_done", done, 1);
      tick();
      zero_dump = 1'b0;
      check("zero_bytes", n_bytes - b0, 0);
      check("zero_done_cnt", n_done - d0, 1);

      // Spurious start and count change while busy
      b0 = n_bytes; d0 = n_done;
      push_exp(1'b0, 3);
      start_dump(1'b0, 9'd3);
      repeat (4) tick();
      start_dump(1'b0, 9'd7);
      count = 9'd1;
      wait_done(1'b0, d0 + 1, 200);
      repeat (3) tick();
      check("ignored_start_bytes", n_bytes - b0, 15);
      check("ignored_start_done", n_done - d0, 1);

      // Reset mid-SEND, then fresh dump of a zero word
      mon_en = 1'b0;
      start_dump(1'b0, 9'd2);
      tick(); tick();
      check("pre_abort_valid", tx_valid, 1);
      rst_n = 1'b0;
      #1;
      check("abort_valid_async", tx_valid, 0);
      tick();
      rst_n = 1'b1;
      mon_en = 1'b1;
      check_idle_outputs();
      mem[0] = 16'h0000;
      d0 = n_done;
      push_exp(1'b0, 1);
      start_dump(1'b0, 9'd1);
      wait_done(1'b0, d0 + 1, 50);

      // Abort during word 2 of 4, then restart from address 0
      mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;
      mon_en = 1'b0;
      start_dump(1'b0, 9'd4);
      repeat (17) tick();
      check("abort_in_word2", addr, 2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      mon_en = 1'b1;
      tick();
      b0 = n_bytes; d0 = n_done;
      push_exp(1'b0, 2);
      start_dump(1'b0, 9'd2);
      wait_done(1'b0, d0 + 1, 100);
      check("recover_bytes", n_bytes - b0, 10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
